dsp_core_alu_pipe: RTL and testbench
====================================

// Module: dsp_core_alu_pipe
// PURPOSE
//  Fully pipelined successor to the sequential DSP-core ALU: accepts one op per cycle, fixed 3-cycle latency.
//  Single-cycle barrel shifter, saturation, N_ACC per-channel wide accumulators for MAC, single-pass linear interp.
//  Sits between the DSP-core instruction decoder and the register file write-back; valid/ready on both sides.
// PARAMETERS
//  DATA_WIDTH   16  operand/result width W (W >= 8, power of two)
//  INTERP_BITS   8  fraction bits used by LINTERP (IB <= W-1)
//  N_ACC         4  number of internal 2W-bit accumulators (>= 1)
// PORTS
//  clk         in   1        clock; all logic rising-edge
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        issue strobe
//  in_ready    out  1        ALU can accept op this cycle
//  op          in   4        0 ADD,1 SUB,2 MUL,3 MADD,4 MAC,5 LSH,6 RSH,7 ARSH,8 MIN,9 MAX,10 ABS,11 LINTERP,12 ACC_CLR,13 ACC_RD
//  a, b, c     in   W each   signed operands
//  shift       in   $clog2(2W)  product right-shift for MUL/MADD/MAC
//  saturate    in   1        clamp narrow result to [-2^(W-1), 2^(W-1)-1]
//  acc_sel     in   max(1,$clog2(N_ACC))  accumulator index (MAC/ACC_CLR/ACC_RD)
//  out_valid   out  1        result present
//  out_ready   in   1        consumer accepts result
//  result      out  W        signed narrow result
//  result_wide out  2W       signed wide result (product / accumulator value)
// BEHAVIOUR
//  Reset: out_valid=0, result=0, result_wide=0, all accumulators=0, stage valids=0; in_ready=1 the cycle after reset.
//  Handshake: op taken when in_valid&&in_ready; result retired when out_valid&&out_ready.
//  Stall: stall = out_valid && !out_ready; in_ready = !stall; whole pipe freezes (incl. accumulators) while stalled.
//  Latency: op accepted at cycle t -> out_valid at t+3 absent stall; throughput 1/cycle; order preserved.
//  S1: latch op/operands; p = a*b (2W signed); LINTERP p = (b-a)*frac, frac = c[W-2 : W-1-IB] zero-extended.
//  S2: barrel shift in one cycle; MUL/MADD/MAC: s = p>>>shift; MADD: s + sext(c); MAC: acc[sel] <= acc[sel] + s.
//      LINTERP: a + (p>>>IB). ACC_CLR: acc[sel] <= 0. Read-modify-write of acc in S2 only -> back-to-back MAC to
//      same acc_sel needs no forwarding; each MAC sees all earlier MACs.
//  S3: narrow = saturate ? clamp(wide) : wide[W-1:0]; register result/result_wide; result_wide = full 2W value.
//  ADD/SUB computed at W+1 bits then clamped/truncated; ABS of -2^(W-1) = 2^(W-1)-1 if saturate else -2^(W-1).
//  MAC: result_wide = new acc value; result = its saturated/truncated narrow form. Accumulator itself wraps (no sat).
//  ACC_RD: result_wide = acc[sel], result = narrow form; ACC_CLR returns result_wide = 0.
//  LSH/RSH/ARSH shift a by b (unsigned): b>=W -> LSH/RSH give 0, ARSH gives {W{a[W-1]}}; b=0 -> a.
//  MIN/MAX signed compare; result_wide = sign-extended result for all narrow ops.
//  acc_sel >= N_ACC: op still completes, accumulators untouched, result_wide=0.
//  Undefined op codes (14,15): complete with result=0, result_wide=0, out_valid asserted as normal.
//  Simultaneous in and out handshake on a full pipe: both occur, no bubble.
//  Reset mid-operation: all in-flight ops discarded, no out_valid after reset, accumulators cleared.
// TESTING (W=16, IB=8, N_ACC=4)
//  ADD a=0x7000 b=0x2000 saturate=1 -> result 0x7FFF at t+3; saturate=0 -> 0x9000.
//  MUL a=0x4000 b=0x4000 shift=15 -> result_wide 0x00002000, result 0x2000; shift=0 sat=1 -> result 0x7FFF.
//  MAC x4 back-to-back acc_sel=2, a=0x0100 b=0x0100 shift=0 -> result_wide 0x10000,0x20000,0x30000,0x40000; ACC_RD sel=1 -> 0.
//  ARSH a=0x8000 b=20 -> 0xFFFF; LSH a=0x0001 b=16 -> 0; RSH a=0x8000 b=15 -> 0x0001.
//  LINTERP a=0 b=0x1000 c=0x4000 (frac=0x80) -> result 0x0800.
//  Stream 10 random ops, hold out_ready=0 cycles 4-7 -> in_ready low, no result lost/duplicated, order matches model.

Source files
------------

// File: rtl/dsp_core_alu_pipe.sv
// rtl/dsp_core_alu_pipe.sv - three-stage pipelined DSP ALU: multiply, barrel shift, saturation, MAC accumulators
module dsp_core_alu_pipe #(
   parameter int DATA_WIDTH  = 16,
   parameter int INTERP_BITS = 8,
   parameter int N_ACC       = 4,
   localparam int SHW = $clog2(2 * DATA_WIDTH),
   localparam int AW  = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [3:0]                     op,
   input  logic signed [DATA_WIDTH-1:0]   a,
   input  logic signed [DATA_WIDTH-1:0]   b,
   input  logic signed [DATA_WIDTH-1:0]   c,
   input  logic [SHW-1:0]                 shift,
   input  logic                           saturate,
   input  logic [AW-1:0]                  acc_sel,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [DATA_WIDTH-1:0]   result,
   output logic signed [2*DATA_WIDTH-1:0] result_wide
);
   localparam int W  = DATA_WIDTH;
   localparam int IB = INTERP_BITS;
   localparam int SB = $clog2(W);

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_MADD = 4'd3,
                          OP_MAC = 4'd4, OP_LSH = 4'd5, OP_RSH = 4'd6, OP_ARSH = 4'd7,
                          OP_MIN = 4'd8, OP_MAX = 4'd9, OP_ABS = 4'd10, OP_LINTERP = 4'd11,
                          OP_ACC_CLR = 4'd12, OP_ACC_RD = 4'd13;

   localparam logic signed [2*W-1:0] NARROW_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] NARROW_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   function automatic logic signed [2*W-1:0] sx(input logic signed [W-1:0] v);
      return {{W{v[W-1]}}, v};
   endfunction

   logic stall, adv;
   assign stall    = out_valid && !out_ready;
   assign adv      = !stall;
   assign in_ready = adv;

   // One shared multiplier: a*b normally, (b-a)*frac for LINTERP; operands sign-extended to 2W
   logic signed [W:0]     diff, mul_x, mul_y;
   logic [2*W-1:0]        prod;
   assign diff  = {b[W-1], b} - {a[W-1], a};
   assign mul_x = (op == OP_LINTERP) ? diff : {a[W-1], a};
   assign mul_y = (op == OP_LINTERP) ? {{(W+1-IB){1'b0}}, c[W-2 -: IB]} : {b[W-1], b};
   assign prod  = {{(W-1){mul_x[W]}}, mul_x} * {{(W-1){mul_y[W]}}, mul_y};

   logic                  v1, sat1;
   logic [3:0]            op1;
   logic signed [W-1:0]   a1, b1, c1;
   logic [SHW-1:0]        sh1;
   logic [AW-1:0]         sel1;
   logic signed [2*W-1:0] p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0; sat1 <= 1'b0; op1 <= '0; a1 <= '0; b1 <= '0; c1 <= '0;
         sh1 <= '0; sel1 <= '0; p1 <= '0;
      end else if (adv) begin
         v1 <= in_valid; sat1 <= saturate; op1 <= op; a1 <= a; b1 <= b; c1 <= c;
         sh1 <= shift; sel1 <= acc_sel; p1 <= prod;
      end
   end

   logic signed [2*W-1:0] acc [N_ACC];
   logic signed [2*W-1:0] s_prod, acc_cur, acc_nxt, wide_n;
   logic                  sel_ok, big, acc_we, is_wide_n;
   logic [SB-1:0]         amt;
   logic [W-1:0]          shl, shr;
   logic signed [W-1:0]   sar;

   assign sel_ok  = int'(sel1) < N_ACC;
   assign acc_cur = sel_ok ? acc[sel1] : '0;
   assign s_prod  = p1 >>> sh1;
   assign amt     = b1[SB-1:0];
   assign big     = |b1[W-1:SB];
   assign shl     = a1 << amt;
   assign shr     = $unsigned(a1) >> amt;
   assign sar     = a1 >>> amt;

   always_comb begin
      wide_n = '0; is_wide_n = 1'b0; acc_we = 1'b0; acc_nxt = acc_cur;
      case (op1)
         OP_ADD:  wide_n = sx(a1) + sx(b1);
         OP_SUB:  wide_n = sx(a1) - sx(b1);
         OP_MUL:  begin wide_n = s_prod; is_wide_n = 1'b1; end
         OP_MADD: begin wide_n = s_prod + sx(c1); is_wide_n = 1'b1; end
         OP_MAC: begin
            is_wide_n = 1'b1;
            if (sel_ok) begin
               acc_nxt = acc_cur + s_prod;
               acc_we  = 1'b1;
               wide_n  = acc_nxt;
            end
         end
         OP_LSH:     wide_n = sx(big ? '0 : shl);
         OP_RSH:     wide_n = sx(big ? '0 : shr);
         OP_ARSH:    wide_n = sx(big ? {W{a1[W-1]}} : sar);
         OP_MIN:     wide_n = (a1 < b1) ? sx(a1) : sx(b1);
         OP_MAX:     wide_n = (a1 > b1) ? sx(a1) : sx(b1);
         OP_ABS:     wide_n = a1[W-1] ? -sx(a1) : sx(a1);
         OP_LINTERP: wide_n = sx(a1) + (p1 >>> IB);
         OP_ACC_CLR: begin
            is_wide_n = 1'b1;
            if (sel_ok) begin
               acc_we  = 1'b1;
               acc_nxt = '0;
            end
         end
         OP_ACC_RD: begin wide_n = acc_cur; is_wide_n = 1'b1; end
         default: ;
      endcase
   end

   logic                  v2, sat2, isw2;
   logic signed [2*W-1:0] wide2;

   // Accumulator read-modify-write happens only here, so back-to-back MACs see each other without forwarding
   always_ff @(posedge clk) begin
      if (reset) begin
         v2 <= 1'b0; sat2 <= 1'b0; isw2 <= 1'b0; wide2 <= '0;
         for (int i = 0; i < N_ACC; i++) acc[i] <= '0;
      end else if (adv) begin
         v2 <= v1; sat2 <= sat1; isw2 <= is_wide_n; wide2 <= wide_n;
         if (v1 && acc_we) acc[sel1] <= acc_nxt;
      end
   end

   logic signed [W-1:0] narrow;
   always_comb begin
      narrow = wide2[W-1:0];
      if (sat2) begin
         if (wide2 > NARROW_MAX)      narrow = NARROW_MAX[W-1:0];
         else if (wide2 < NARROW_MIN) narrow = NARROW_MIN[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0; result <= '0; result_wide <= '0;
      end else if (adv) begin
         out_valid <= v2;
         if (v2) begin
            result      <= narrow;
            result_wide <= isw2 ? wide2 : sx(narrow);
         end
      end
   end
endmodule

// File: tb/tb_dsp_core_alu_pipe.sv
// tb/tb_dsp_core_alu_pipe.sv - directed-vector bench for dsp_core_alu_pipe
module tb_dsp_core_alu_pipe;
   localparam logic [3:0] O_ADD = 4'd0, O_SUB = 4'd1, O_MUL = 4'd2, O_MADD = 4'd3, O_MAC = 4'd4,
                          O_LSH = 4'd5, O_RSH = 4'd6, O_ARSH = 4'd7, O_MIN = 4'd8, O_MAX = 4'd9,
                          O_ABS = 4'd10, O_LIN = 4'd11, O_CLR = 4'd12, O_RD = 4'd13;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a, b, c;
      logic [4:0]  sh;
      logic        sat;
      logic [1:0]  sel;
      logic [15:0] er;
      logic [31:0] ew;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1, saturate = 1'b0;
   logic [3:0]  op = '0;
   logic [15:0] a = '0, b = '0, c = '0;
   logic [4:0]  shift = '0;
   logic [1:0]  acc_sel = '0;
   logic        in_ready, out_valid;
   logic [15:0] result;
   logic [31:0] result_wide;
   int checks = 0, errors = 0, cyc = 0;
   logic [47:0] obs[$];
   int obs_cyc[$];

   dsp_core_alu_pipe #(.DATA_WIDTH(16), .INTERP_BITS(8), .N_ACC(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c(c), .shift(shift), .saturate(saturate), .acc_sel(acc_sel),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_wide(result_wide));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (!reset && out_valid && out_ready) begin
         obs.push_back({result, result_wide});
         obs_cyc.push_back(cyc);
      end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [47:0] pop_obs();
      if (obs.size() == 0) return 48'hDEAD_DEAD_DEAD;
      void'(obs_cyc.pop_front());
      return obs.pop_front();
   endfunction

   task automatic issue(input vec_t v);
      logic rdy = 1'b0;
      op = v.op; a = v.a; b = v.b; c = v.c; shift = v.sh; saturate = v.sat; acc_sel = v.sel;
      in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) break;
      end
      checks++;
      if (!rdy) begin errors++; $display("FAIL issue_timeout op=%0d got in_ready=0 want 1", v.op); end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      checks++; if (result_wide !== 32'h0) begin errors++; $display("FAIL reset_result_wide got %h want 0", result_wide); end
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      vec_t v[4];
      logic [2:0] lat;
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      op = O_ADD; a = 16'h7000; b = 16'h2000; saturate = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); lat[2] = out_valid;
      @(negedge clk); lat[1] = out_valid;
      @(negedge clk); lat[0] = out_valid;
      checks++; if (lat !== 3'b001) begin errors++; $display("FAIL add_latency got %b want 001", lat); end
      checks++; if (result !== 16'h7FFF) begin errors++; $display("FAIL add_latency_result got %h want 7fff", result); end
      @(posedge clk); #1;
      repeat (3) @(posedge clk); #1;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_ADD, 16'h7000, 16'h2000, 16'h0, 5'd0, 1'b1, 2'd0, 16'h7FFF, 32'h00007FFF},
            '{O_ADD, 16'h7000, 16'h2000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h9000, 32'hFFFF9000},
            '{O_SUB, 16'h8000, 16'h0001, 16'h0, 5'd0, 1'b1, 2'd0, 16'h8000, 32'hFFFF8000},
            '{O_SUB, 16'h8000, 16'h0001, 16'h0, 5'd0, 1'b0, 2'd0, 16'h7FFF, 32'h00007FFF}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL add[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_mul();
      vec_t v[5];
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_MUL,  16'h4000, 16'h4000, 16'h0,    5'd15, 1'b0, 2'd0, 16'h2000, 32'h00002000},
            '{O_MUL,  16'h4000, 16'h4000, 16'h0,    5'd0,  1'b1, 2'd0, 16'h7FFF, 32'h10000000},
            '{O_MUL,  16'h4000, 16'h4000, 16'h0,    5'd0,  1'b0, 2'd0, 16'h0000, 32'h10000000},
            '{O_MADD, 16'h0010, 16'hFFFE, 16'h0005, 5'd0,  1'b0, 2'd0, 16'hFFE5, 32'hFFFFFFE5},
            '{O_MUL,  16'hFFFF, 16'h0001, 16'h0,    5'd4,  1'b0, 2'd0, 16'hFFFF, 32'hFFFFFFFF}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL mul[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_back_to_back_mac();
      vec_t v[11];
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_CLR, 16'h0,    16'h0,    16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00000000},
            '{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00010000},
            '{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00020000},
            '{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00030000},
            '{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00040000},
            '{O_RD,  16'h0,    16'h0,    16'h0, 5'd0, 1'b0, 2'd1, 16'h0000, 32'h00000000},
            '{O_RD,  16'h0,    16'h0,    16'h0, 5'd0, 1'b1, 2'd2, 16'h7FFF, 32'h00040000},
            '{O_CLR, 16'h0,    16'h0,    16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00000000},
            '{O_RD,  16'h0,    16'h0,    16'h0, 5'd0, 1'b0, 2'd2, 16'h0000, 32'h00000000},
            '{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd8, 1'b0, 2'd3, 16'h0100, 32'h00000100},
            '{O_MAC, 16'hFF00, 16'h0100, 16'h0, 5'd0, 1'b1, 2'd3, 16'h8000, 32'hFFFF0100}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      checks++;
      if (obs_cyc.size() < 5) begin errors++; $display("FAIL mac_count got %0d want 11", obs_cyc.size()); end
      else for (int i = 1; i < 5; i++) begin
         checks++;
         if (obs_cyc[i] - obs_cyc[i-1] != 1) begin
            errors++; $display("FAIL mac_gap[%0d] got %0d want 1", i, obs_cyc[i] - obs_cyc[i-1]);
         end
      end
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL mac[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_shift();
      vec_t v[9];
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_ARSH, 16'h8000, 16'h0014, 16'h0, 5'd0, 1'b0, 2'd0, 16'hFFFF, 32'hFFFFFFFF},
            '{O_LSH,  16'h0001, 16'h0010, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0000, 32'h00000000},
            '{O_RSH,  16'h8000, 16'h000F, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0001, 32'h00000001},
            '{O_LSH,  16'h1234, 16'h0000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h1234, 32'h00001234},
            '{O_ARSH, 16'h8000, 16'h0004, 16'h0, 5'd0, 1'b0, 2'd0, 16'hF800, 32'hFFFFF800},
            '{O_RSH,  16'h8000, 16'h0004, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0800, 32'h00000800},
            '{O_LSH,  16'h0003, 16'h000F, 16'h0, 5'd0, 1'b0, 2'd0, 16'h8000, 32'hFFFF8000},
            '{O_ARSH, 16'h4000, 16'h0010, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0000, 32'h00000000},
            '{O_LSH,  16'hFFFF, 16'h8000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0000, 32'h00000000}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL shift[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_linterp();
      vec_t v[4];
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_LIN, 16'h0000, 16'h1000, 16'h4000, 5'd0, 1'b0, 2'd0, 16'h0800, 32'h00000800},
            '{O_LIN, 16'h1000, 16'h0000, 16'h4000, 5'd0, 1'b0, 2'd0, 16'h0800, 32'h00000800},
            '{O_LIN, 16'h0000, 16'h0100, 16'h7FFF, 5'd0, 1'b0, 2'd0, 16'h00FF, 32'h000000FF},
            '{O_LIN, 16'h7F00, 16'h8000, 16'h7FFF, 5'd0, 1'b0, 2'd0, 16'h80FF, 32'hFFFF80FF}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL linterp[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_misc();
      vec_t v[7];
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_MIN,  16'hFFFE, 16'h0003, 16'h0, 5'd0, 1'b0, 2'd0, 16'hFFFE, 32'hFFFFFFFE},
            '{O_MAX,  16'hFFFE, 16'h0003, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0003, 32'h00000003},
            '{O_ABS,  16'h8000, 16'h0000, 16'h0, 5'd0, 1'b1, 2'd0, 16'h7FFF, 32'h00007FFF},
            '{O_ABS,  16'h8000, 16'h0000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h8000, 32'hFFFF8000},
            '{O_ABS,  16'hFFF0, 16'h0000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0010, 32'h00000010},
            '{4'd14,  16'h1234, 16'h5678, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0000, 32'h00000000},
            '{4'd15,  16'h1234, 16'h5678, 16'h0, 5'd0, 1'b1, 2'd0, 16'h0000, 32'h00000000}};
      foreach (v[i]) issue(v[i]);
      repeat (6) @(posedge clk); #1;
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL misc[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_stall_stream();
      vec_t v[10];
      logic [47:0] got;
      logic saw_low = 1'b0;
      obs.delete(); obs_cyc.delete();
      v = '{'{O_ADD, 16'h0001, 16'h0002, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0003, 32'h00000003},
            '{O_SUB, 16'h0005, 16'h0007, 16'h0, 5'd0, 1'b0, 2'd0, 16'hFFFE, 32'hFFFFFFFE},
            '{O_MAX, 16'h0100, 16'h0200, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0200, 32'h00000200},
            '{O_MIN, 16'h0100, 16'hFF00, 16'h0, 5'd0, 1'b0, 2'd0, 16'hFF00, 32'hFFFFFF00},
            '{O_LSH, 16'h0001, 16'h0004, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0010, 32'h00000010},
            '{O_ADD, 16'h0010, 16'h0020, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0030, 32'h00000030},
            '{O_RSH, 16'h00F0, 16'h0004, 16'h0, 5'd0, 1'b0, 2'd0, 16'h000F, 32'h0000000F},
            '{O_MUL, 16'h0003, 16'h0004, 16'h0, 5'd0, 1'b0, 2'd0, 16'h000C, 32'h0000000C},
            '{O_ABS, 16'hFFFB, 16'h0000, 16'h0, 5'd0, 1'b0, 2'd0, 16'h0005, 32'h00000005},
            '{O_SUB, 16'h0000, 16'h0001, 16'h0, 5'd0, 1'b0, 2'd0, 16'hFFFF, 32'hFFFFFFFF}};
      fork
         foreach (v[i]) issue(v[i]);
         begin
            repeat (4) @(posedge clk); #1 out_ready = 1'b0;
            repeat (4) @(posedge clk); #1 out_ready = 1'b1;
         end
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
         end
      join
      repeat (8) @(posedge clk); #1;
      checks++; if (saw_low !== 1'b1) begin errors++; $display("FAIL stall_in_ready got never-low want low"); end
      checks++; if (obs.size() != 10) begin errors++; $display("FAIL stream_count got %0d want 10", obs.size()); end
      foreach (v[i]) begin
         got = pop_obs(); checks++;
         if (got !== {v[i].er, v[i].ew}) begin errors++; $display("FAIL stream[%0d] got %h want %h", i, got, {v[i].er, v[i].ew}); end
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] got;
      obs.delete(); obs_cyc.delete();
      issue('{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd3, 16'h0, 32'h0});
      issue('{O_MAC, 16'h0100, 16'h0100, 16'h0, 5'd0, 1'b0, 2'd3, 16'h0, 32'h0});
      reset = 1'b1;
      repeat (2) @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
      repeat (6) @(posedge clk); #1;
      checks++; if (obs.size() != 0) begin errors++; $display("FAIL rst_mid_flushed got %0d want 0", obs.size()); end
      obs.delete(); obs_cyc.delete();
      issue('{O_RD, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0, 2'd3, 16'h0, 32'h0});
      repeat (6) @(posedge clk); #1;
      got = pop_obs(); checks++;
      if (got !== 48'h0) begin errors++; $display("FAIL rst_mid_acc_clear got %h want 0", got); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_back_to_back_mac();
      test_shift();
      test_linterp();
      test_misc();
      test_stall_stream();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
